// File: rtl/chip_despreader.sv
`default_nettype none
// ============================================================================
// Module   : chip_despreader
// Purpose  : O-QPSK chip-to-symbol despreader. Slides a 32-chip window over
//            the serial chip stream, hunts for the symbol-0 preamble code,
//            then, once locked, decodes every 32 valid chips into the
//            nearest of the 16 PN codes (minimum Hamming distance).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_HAM        largest Hamming distance accepted as a valid match (0..15)
//   LOSS_CNT       consecutive rejected symbols that drop lock (1..15)
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_chip         serial chip
//   i_chip_valid   i_chip qualifier (arbitrary gaps allowed)
//   i_resync       abandon lock, clear window and counters, re-hunt
//   o_symbol       decoded symbol (held between strobes)
//   o_symbol_valid one-cycle strobe qualifying o_symbol / o_sym_err
//   o_sym_err      selected minimum distance exceeded MAX_HAM
//   o_locked       high while in the LOCKED state
//   o_min_dist     selected minimum distance (only with
//                  CHIP_DESPREADER_DIST_EN defined)
// ============================================================================
module chip_despreader #(
    parameter int MAX_HAM  = 6,
    parameter int LOSS_CNT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_chip,
    input  logic       i_chip_valid,
    input  logic       i_resync,
    output logic [3:0] o_symbol,
    output logic       o_symbol_valid,
    output logic       o_sym_err,
    output logic       o_locked
`ifdef CHIP_DESPREADER_DIST_EN
    ,
    output logic [5:0] o_min_dist
`endif
);

    // Symbol-0 code with bit i holding chip c_i (c0 is the LSB).
    localparam logic [31:0] C_PN0      = 32'h744A_C39B;
    localparam logic [31:0] C_ODD_MASK = 32'hAAAA_AAAA;
    localparam logic [5:0]  C_MAX_HAM  = 6'(MAX_HAM);
    localparam logic [3:0]  C_LOSS_CNT = 4'(LOSS_CNT);

    typedef enum logic [0:0] {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // A cyclic right shift by 4 chips moves chip c_i to c_(i+4), i.e. a
    // rotate towards the MSB in this bit ordering.
    function automatic logic [31:0] ref_code(input int k);
        logic [31:0] code;
        code = C_PN0;
        for (int r = 0; r < (k % 8); r++) begin
            code = {code[27:0], code[31:28]};
        end
        if (k >= 8) begin
            code = code ^ C_ODD_MASK;
        end
        return code;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    state_t      r_state;
    // Only the 31 newest chips are stored: the oldest chip of the full
    // window is needed solely by the compare made while the next chip
    // arrives, and it drops out of the window in that same shift.
    logic [30:0] r_win_tail;
    logic [4:0]  r_chip_cnt;
    logic [3:0]  r_bad_cnt;
    logic [3:0]  r_symbol;
    logic        r_symbol_valid;
    logic        r_sym_err;

    logic [31:0] w_window;
    logic [5:0]  w_dist [16];
    logic [5:0]  w_best_dist;
    logic [3:0]  w_best_idx;
    logic        w_advance;
    logic        w_hunt_hit;
    logic        w_sym_done;
    logic        w_reject;
    logic [3:0]  w_bad_inc;

    // Window as it will look after the current chip: newest chip at c31.
    assign w_window = {i_chip, r_win_tail};

    for (genvar k = 0; k < 16; k++) begin : g_dist
        localparam logic [31:0] C_CODE = ref_code(k);
        assign w_dist[k] = popcount(w_window ^ C_CODE);
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_dist = w_dist[0];
        w_best_idx  = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w_dist[k] < w_best_dist) begin
                w_best_dist = w_dist[k];
                w_best_idx  = 4'(k);
            end
        end
    end

    // A resync discards any chip presented in the same cycle.
    assign w_advance  = i_chip_valid && !i_resync;
    assign w_hunt_hit = (r_state == S_HUNT) && (w_dist[0] <= C_MAX_HAM);
    assign w_sym_done = (r_state == S_LOCKED) && (r_chip_cnt == 5'd31);
    assign w_reject   = (w_best_dist > C_MAX_HAM);
    assign w_bad_inc  = r_bad_cnt + 4'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_HUNT;
            r_win_tail     <= '0;
            r_chip_cnt     <= '0;
            r_bad_cnt      <= '0;
            r_symbol       <= '0;
            r_symbol_valid <= 1'b0;
            r_sym_err      <= 1'b0;
        end else begin
            r_symbol_valid <= 1'b0;
            if (i_resync) begin
                r_state    <= S_HUNT;
                r_win_tail <= '0;
                r_chip_cnt <= '0;
                r_bad_cnt  <= '0;
            end else if (i_chip_valid) begin
                r_win_tail <= w_window[31:1];
                case (r_state)
                    S_HUNT: begin
                        if (w_hunt_hit) begin
                            r_state        <= S_LOCKED;
                            r_symbol_valid <= 1'b1;
                            r_symbol       <= 4'd0;
                            r_sym_err      <= 1'b0;
                            r_chip_cnt     <= '0;
                            r_bad_cnt      <= '0;
                        end
                    end
                    S_LOCKED: begin
                        // Natural 5-bit wrap gives 31 -> 0 on the 32nd chip.
                        r_chip_cnt <= r_chip_cnt + 5'd1;
                        if (w_sym_done) begin
                            r_symbol_valid <= 1'b1;
                            r_symbol       <= w_best_idx;
                            r_sym_err      <= w_reject;
                            if (!w_reject) begin
                                r_bad_cnt <= '0;
                            end else if (w_bad_inc >= C_LOSS_CNT) begin
                                // Window is kept so hunting continues
                                // from the very next chip.
                                r_state   <= S_HUNT;
                                r_bad_cnt <= '0;
                            end else begin
                                r_bad_cnt <= w_bad_inc;
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign o_symbol       = r_symbol;
    assign o_symbol_valid = r_symbol_valid;
    assign o_sym_err      = r_sym_err;
    assign o_locked       = (r_state == S_LOCKED);

`ifdef CHIP_DESPREADER_DIST_EN
    logic [5:0] r_min_dist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min_dist <= '0;
        end else if (w_advance) begin
            if (w_hunt_hit) begin
                r_min_dist <= w_dist[0];
            end else if (w_sym_done) begin
                r_min_dist <= w_best_dist;
            end
        end
    end

    assign o_min_dist = r_min_dist;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chip_despreader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_chip_despreader
// Purpose  : Self-checking bench for chip_despreader. A behavioural model
//            built from the symbol table (chip strings, queues, plain
//            counting) predicts every output every cycle; a table of
//            symbol-level vectors and short directed sequences cover lock,
//            error tolerance, loss of lock, resync, reset and gapped input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip_despreader;

    localparam int MAX_HAM  = 6;
    localparam int LOSS_CNT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       chip = 1'b0;
    logic       chip_valid = 1'b0;
    logic       resync = 1'b0;
    logic [3:0] sym;
    logic       sym_valid;
    logic       sym_err;
    logic       locked;
`ifdef CHIP_DESPREADER_DIST_EN
    logic [5:0] min_dist;
`endif

    always #5 clk = ~clk;

    chip_despreader #(.MAX_HAM(MAX_HAM), .LOSS_CNT(LOSS_CNT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_chip         (chip),
        .i_chip_valid   (chip_valid),
        .i_resync       (resync),
        .o_symbol       (sym),
        .o_symbol_valid (sym_valid),
        .o_sym_err      (sym_err),
        .o_locked       (locked)
`ifdef CHIP_DESPREADER_DIST_EN
        ,
        .o_min_dist     (min_dist)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int   refc [16][32];      // refc[k][j] = chip c_j of symbol k
    int   win_q [$];          // last 32 chips, oldest first
    bit   m_locked;
    int   m_since;
    int   m_bad;
    int   e_valid, e_sym, e_err, e_locked, e_dist;

    int   last_strobe;
    int   strobe_log [$];

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic build_refs();
        string pn;
        byte   b;
        pn = "11011001110000110101001000101110";
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 32; j++) begin
                b = pn[(j - 4 * (k % 8) + 32) % 32];
                refc[k][j] = (b == 8'h31) ? 1 : 0;
                if (k >= 8 && (j % 2) == 1) refc[k][j] = 1 - refc[k][j];
            end
        end
    endtask

    function automatic logic [31:0] ref_bits(input int k);
        logic [31:0] v;
        for (int j = 0; j < 32; j++) v[j] = refc[k][j][0];
        return v;
    endfunction

    // Best match of an arbitrary 32-chip vector (bit j = chip c_j).
    task automatic decode_vec(input logic [31:0] v, output int best, output int bd);
        int d;
        best = 0;
        bd   = 99;
        for (int k = 0; k < 16; k++) begin
            d = 0;
            for (int j = 0; j < 32; j++) if (int'(v[j]) != refc[k][j]) d++;
            if (d < bd) begin
                bd   = d;
                best = k;
            end
        end
    endtask

    function automatic logic [31:0] window_vec();
        logic [31:0] v;
        for (int j = 0; j < 32; j++) v[j] = win_q[j][0];
        return v;
    endfunction

    task automatic model_clear();
        win_q.delete();
        repeat (32) win_q.push_back(0);
        m_locked = 1'b0;
        m_since  = 0;
        m_bad    = 0;
    endtask

    task automatic model_reset();
        model_clear();
        e_valid = 0; e_sym = 0; e_err = 0; e_locked = 0; e_dist = 0;
    endtask

    task automatic model_step(input logic c, input logic v, input logic rs);
        int best, bd, d0;
        logic [31:0] wv;
        e_valid = 0;
        if (rs) begin
            model_clear();
        end else if (v) begin
            win_q.push_back(int'(c));
            void'(win_q.pop_front());
            wv = window_vec();
            if (!m_locked) begin
                d0 = 0;
                for (int j = 0; j < 32; j++) if (int'(wv[j]) != refc[0][j]) d0++;
                if (d0 <= MAX_HAM) begin
                    m_locked = 1'b1;
                    m_since  = 0;
                    m_bad    = 0;
                    e_valid  = 1; e_sym = 0; e_err = 0; e_dist = d0;
                end
            end else begin
                m_since++;
                if (m_since == 32) begin
                    m_since = 0;
                    decode_vec(wv, best, bd);
                    e_valid = 1; e_sym = best; e_dist = bd;
                    e_err   = (bd > MAX_HAM) ? 1 : 0;
                    if (e_err == 0) begin
                        m_bad = 0;
                    end else begin
                        m_bad++;
                        if (m_bad >= LOSS_CNT) begin
                            m_locked = 1'b0;
                            m_bad    = 0;
                        end
                    end
                end
            end
        end
        e_locked = m_locked ? 1 : 0;
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input logic c, input logic v, input logic rs);
        chip = c; chip_valid = v; resync = rs;
        model_step(c, v, rs);
        @(posedge clk); #1;
        last_strobe = int'(sym_valid);
        if (sym_valid) strobe_log.push_back(int'(sym));
        check_val("symbol_valid", int'(sym_valid), e_valid);
        check_val("locked", int'(locked), e_locked);
        check_val("symbol", int'(sym), e_sym);
        check_val("sym_err", int'(sym_err), e_err);
`ifdef CHIP_DESPREADER_DIST_EN
        check_val("min_dist", int'(min_dist), e_dist);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_symbol"}, int'(sym), 0);
        check_val({tag, "_valid"}, int'(sym_valid), 0);
        check_val({tag, "_err"}, int'(sym_err), 0);
        check_val({tag, "_locked"}, int'(locked), 0);
`ifdef CHIP_DESPREADER_DIST_EN
        check_val({tag, "_min_dist"}, int'(min_dist), 0);
`endif
    endtask

    task automatic do_reset(input int n);
        chip = 1'b0; chip_valid = 1'b0; resync = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("rst_async");
        repeat (n) begin
            @(posedge clk); #1;
            check_all_zero("rst_hold");
        end
        rst = 1'b0;
    endtask

    // duty = percentage of cycles carrying a valid chip (100 = gap-free).
    task automatic send_chips(input int k, input logic [31:0] flips,
                              input int first, input int count, input int duty);
        for (int j = first; j < first + count; j++) begin
            if (duty < 100) begin
                for (int g = 0; g < 40 && $urandom_range(99) >= duty; g++)
                    tick(1'($urandom_range(1)), 1'b0, 1'b0);
            end
            tick(1'(refc[k][j]) ^ flips[j], 1'b1, 1'b0);
        end
    endtask

    task automatic send_symbol(input int k, input logic [31:0] flips, input int duty);
        send_chips(k, flips, 0, 32, duty);
    endtask

    // ---------------- symbol-level vector table ----------------
    typedef struct {
        string       name;
        int          sym;
        logic [31:0] flips;
        int          exp_sym;
        int          exp_err;
        int          exp_locked;
    } vec_t;

    vec_t vt [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before, bs, bd;
        int seq [12];
        int clean_log [$];
        int k;
        logic [31:0] f;

        build_refs();

        // Expected symbol/err for the noisy vectors come from the
        // independent best-match search; clean and all-zero ones are exact.
        vt[0] = '{"sym_A_clean", 10, 32'h0, 10, 0, 1};
        decode_vec(ref_bits(5) ^ 32'h0022_2222, bs, bd);
        vt[1] = '{"sym_5_flip6", 5, 32'h0022_2222, bs, (bd > MAX_HAM) ? 1 : 0, 1};
        decode_vec(ref_bits(5) ^ 32'h0222_2222, bs, bd);
        vt[2] = '{"sym_5_flip7", 5, 32'h0222_2222, bs, (bd > MAX_HAM) ? 1 : 0, 1};
        vt[3] = '{"sym_3_clean", 3, 32'h0, 3, 0, 1};
        // All-zero chips: symbol 0 with its 16 ones flipped, distance 16 to all.
        vt[4] = '{"bad_1", 0, ref_bits(0), 0, 1, 1};
        vt[5] = '{"bad_2", 0, ref_bits(0), 0, 1, 1};
        vt[6] = '{"bad_3", 0, ref_bits(0), 0, 1, 0};

        // ---- reset, preamble lock, table ----
        do_reset(3);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        strobe_log.delete();
        send_symbol(0, 32'h0, 100);
        check_val("preamble_lock_on_chip32", last_strobe, 1);
        check_val("preamble_single_strobe", strobe_log.size(), 1);
        check_val("preamble_locked", int'(locked), 1);
        send_symbol(0, 32'h0, 100);
        check_val("preamble2_strobe", last_strobe, 1);
        check_val("preamble2_symbol", int'(sym), 0);
        for (int i = 0; i < 7; i++) begin
            send_symbol(vt[i].sym, vt[i].flips, 100);
            check_val({vt[i].name, "_strobe"}, last_strobe, 1);
            check_val({vt[i].name, "_symbol"}, int'(sym), vt[i].exp_sym);
            check_val({vt[i].name, "_err"}, int'(sym_err), vt[i].exp_err);
            check_val({vt[i].name, "_locked"}, int'(locked), vt[i].exp_locked);
        end
        // Outputs hold after the final strobe.
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        check_val("hold_symbol", int'(sym), 0);
        check_val("hold_err", int'(sym_err), 1);

        // ---- resync coincident with the 32nd chip ----
        do_reset(2);
        send_symbol(0, 32'h0, 100);
        send_chips(7, 32'h0, 0, 31, 100);
        n_before = strobe_log.size();
        tick(1'(refc[7][31]), 1'b1, 1'b1);
        check_val("resync_no_strobe", last_strobe, 0);
        check_val("resync_unlocked", int'(locked), 0);
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        check_val("resync_quiet", strobe_log.size(), n_before);
        send_symbol(0, 32'h0, 100);
        check_val("resync_relock_strobe", last_strobe, 1);
        check_val("resync_relock_locked", int'(locked), 1);

        // ---- reset at chip 17 of a symbol ----
        do_reset(2);
        send_symbol(0, 32'h0, 100);
        send_chips(9, 32'h0, 0, 17, 100);
        do_reset(2);
        n_before = strobe_log.size();
        repeat (40) tick(1'b0, 1'b0, 1'b0);
        check_val("reset_mid_no_strobe", strobe_log.size(), n_before);
        send_symbol(0, 32'h0, 100);
        check_val("reset_relock_strobe", last_strobe, 1);
        check_val("reset_relock_locked", int'(locked), 1);

        // ---- gap-free vs 30% duty must decode the same sequence ----
        for (int i = 0; i < 12; i++) seq[i] = $urandom_range(15);
        do_reset(2);
        send_symbol(0, 32'h0, 100);
        strobe_log.delete();
        for (int i = 0; i < 12; i++) send_symbol(seq[i], 32'h0, 100);
        clean_log = strobe_log;
        do_reset(2);
        send_symbol(0, 32'h0, 30);
        strobe_log.delete();
        for (int i = 0; i < 12; i++) send_symbol(seq[i], 32'h0, 30);
        check_val("gap_seq_len", strobe_log.size(), 12);
        check_val("clean_seq_len", clean_log.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < strobe_log.size()) check_val("gap_seq_symbol", strobe_log[i], seq[i]);
            if (i < clean_log.size()) check_val("clean_seq_symbol", clean_log[i], seq[i]);
        end

        // ---- random noisy stream with occasional resync ----
        do_reset(2);
        send_symbol(0, 32'h0, 100);
        for (int s = 0; s < 60; s++) begin
            k = ($urandom_range(3) == 0) ? 0 : $urandom_range(15);
            f = 32'h0;
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(12, 1)) f[$urandom_range(31)] = 1'b1;
            end
            send_symbol(k, f, 60);
            if ($urandom_range(9) == 0)
                tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        end
        repeat (5) tick(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
